operand_bypass_ctrl: RTL and testbench

Forwarding and load-use control for the execute stage. Tracks the destination registers of the instructions in EX and MEM, and compares them against the source registers of the instruction leaving decode. It produces the registered 2-bit select codes that drive the 32-bit 4-to-1 operand muxes feeding the ALU, and a stall request for load-use hazards. It sits between decode and the EX-stage operand muxes.

---
 rtl/bypass_pkg.sv | 21 ++
 rtl/bypass_match.sv | 23 ++
 rtl/operand_bypass_ctrl.sv | 85 ++++++++
 tb/tb_operand_bypass_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_pkg.sv
// bypass_pkg: select codes, default register-address width and the pipeline-slot record
// shared by the operand bypass controller and its comparators.
package bypass_pkg;

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_EXMEM   = 2'b01;
    localparam logic [1:0] SEL_MEMWB   = 2'b10;
    localparam logic [1:0] SEL_IMM     = 2'b11;

    localparam int DEF_REG_ADDR_W = 5;
    // Slots carry a fixed-width dest so the record type can live here; any REG_ADDR_W up to this fits.
    localparam int SLOT_ADDR_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] dest;
        logic                   we;
        logic                   load;
    } slot_t;

endpackage

// File: rtl/bypass_match.sv
// bypass_match: per-operand comparator; picks the youngest in-flight writer of src
// and flags when that writer is a load still in EX.
module bypass_match
    import bypass_pkg::*;
(
    input  logic [SLOT_ADDR_W-1:0] src,
    input  slot_t                  ex,
    input  slot_t                  mem,
    output logic [1:0]             sel,
    output logic                   ex_load_hit
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit      = ex.valid & ex.we & (ex.dest == src) & (src != '0);
        mem_hit     = mem.valid & mem.we & (mem.dest == src) & (src != '0);
        sel         = ex_hit ? SEL_EXMEM : mem_hit ? SEL_MEMWB : SEL_REGFILE;
        ex_load_hit = ex_hit & ex.load;
    end

endmodule

// File: rtl/operand_bypass_ctrl.sv
// operand_bypass_ctrl: registered EX-stage operand mux selects plus load-use stall request.
// Define BYPASS_STALL_CNT_EN to add the saturating stall_count output.
module operand_bypass_ctrl
    import bypass_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dx_valid,
    input  logic [REG_ADDR_W-1:0] dx_rs1,
    input  logic [REG_ADDR_W-1:0] dx_rs2,
    input  logic                  dx_b_imm,
    input  logic [REG_ADDR_W-1:0] dx_dest,
    input  logic                  dx_we,
    input  logic                  dx_load,
    input  logic                  flush,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic                  stall
`ifdef BYPASS_STALL_CNT_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    slot_t      ex;
    slot_t      mem;
    slot_t      ex_in;
    logic [1:0] nxt_a;
    logic [1:0] nxt_b_raw;
    logic [1:0] nxt_b;
    logic       hit_a;
    logic       hit_b;
    logic       enter;

    bypass_match u_match_a (
        .src         (SLOT_ADDR_W'(dx_rs1)),
        .ex          (ex),
        .mem         (mem),
        .sel         (nxt_a),
        .ex_load_hit (hit_a)
    );

    bypass_match u_match_b (
        .src         (SLOT_ADDR_W'(dx_rs2)),
        .ex          (ex),
        .mem         (mem),
        .sel         (nxt_b_raw),
        .ex_load_hit (hit_b)
    );

    always_comb begin
        stall       = dx_valid & ~flush & (hit_a | (~dx_b_imm & hit_b));
        nxt_b       = dx_b_imm ? SEL_IMM : nxt_b_raw;
        enter       = dx_valid & ~flush & ~stall;
        ex_in       = '0;
        ex_in.valid = 1'b1;
        ex_in.dest  = SLOT_ADDR_W'(dx_dest);
        ex_in.we    = dx_we;
        ex_in.load  = dx_load;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex    <= '0;
            mem   <= '0;
            sel_a <= SEL_REGFILE;
            sel_b <= SEL_REGFILE;
        end else begin
            mem   <= ex;
            ex    <= enter ? ex_in : '0;
            sel_a <= enter ? nxt_a : SEL_REGFILE;
            sel_b <= enter ? nxt_b : SEL_REGFILE;
        end
    end

`ifdef BYPASS_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_count <= '0;
        else        stall_count <= stall_count + {31'd0, stall & ~&stall_count};
    end
`endif

endmodule

// File: tb/tb_operand_bypass_ctrl.sv
// tb_operand_bypass_ctrl: directed scenarios plus randomized traffic checked against an
// in-flight instruction history model.
module tb_operand_bypass_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dx_valid = 1'b0;
    logic [4:0] dx_rs1 = '0;
    logic [4:0] dx_rs2 = '0;
    logic       dx_b_imm = 1'b0;
    logic [4:0] dx_dest = '0;
    logic       dx_we = 1'b0;
    logic       dx_load = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       stall;
`ifdef BYPASS_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    operand_bypass_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .dx_valid (dx_valid),
        .dx_rs1   (dx_rs1),
        .dx_rs2   (dx_rs2),
        .dx_b_imm (dx_b_imm),
        .dx_dest  (dx_dest),
        .dx_we    (dx_we),
        .dx_load  (dx_load),
        .flush    (flush),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .stall    (stall)
`ifdef BYPASS_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit v;
        int dest;
        bit we;
        bit ld;
    } ins_t;

    // hist[0] is the instruction in EX, hist[1] the one in MEM
    ins_t hist[2];
    int   exp_a;
    int   exp_b;
    longint exp_cnt;
    int   asserts = 0;
    int   fails = 0;

    function automatic int fwd(int r);
        if (r == 0) return 0;
        for (int k = 0; k < 2; k++)
            if (hist[k].v && hist[k].we && hist[k].dest == r) return k + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit dep;
        dep = (dx_rs1 != 0 && hist[0].dest == int'(dx_rs1)) ||
              (!dx_b_imm && dx_rs2 != 0 && hist[0].dest == int'(dx_rs2));
        return dx_valid && !flush && hist[0].v && hist[0].ld && hist[0].we && dep;
    endfunction

    task automatic model_reset();
        hist[0] = '{0, 0, 0, 0};
        hist[1] = '{0, 0, 0, 0};
        exp_a = 0;
        exp_b = 0;
        exp_cnt = 0;
    endtask

    task automatic model_step();
        bit s;
        bit enter;
        s = m_stall();
        if (s && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
        enter = dx_valid && !flush && !s;
        exp_a = enter ? fwd(int'(dx_rs1)) : 0;
        exp_b = enter ? (dx_b_imm ? 3 : fwd(int'(dx_rs2))) : 0;
        hist[1] = hist[0];
        hist[0] = enter ? ins_t'{1, int'(dx_dest), dx_we, dx_load} : ins_t'{0, 0, 0, 0};
    endtask

    task automatic drive(bit v, int rs1, int rs2, bit bimm, int dest, bit we, bit ld, bit fl);
        dx_valid = v;
        dx_rs1   = 5'(rs1);
        dx_rs2   = 5'(rs2);
        dx_b_imm = bimm;
        dx_dest  = 5'(dest);
        dx_we    = we;
        dx_load  = ld;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        asserts++;
        if (sel_a !== 2'b00 || sel_b !== 2'b00 || stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: sel_a=%0d sel_b=%0d stall=%0b, need 0 0 0", sel_a, sel_b, stall);
        end
`ifdef BYPASS_STALL_CNT_EN
        asserts++;
        if (stall_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d need 0", stall_count);
        end
`endif
        reset = 1'b1;
        #1;
    endtask

    task automatic test_ex_forward();
        drain();
        drive(1, 1, 2, 0, 3, 1, 0, 0);
        tick();
        drive(1, 3, 5, 0, 4, 1, 0, 0);
        asserts++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL ex_fwd_stall: got %0b need 0", stall);
        end
        tick();
        asserts++;
        if (sel_a !== 2'b01 || sel_b !== 2'b00) begin
            fails++;
            $display("FAIL ex_fwd_sel: sel_a=%0d sel_b=%0d need 1 0", sel_a, sel_b);
        end
    endtask

    task automatic test_mem_forward();
        drain();
        drive(1, 1, 2, 0, 3, 1, 0, 0);
        tick();
        drive(1, 1, 2, 0, 10, 1, 0, 0);
        tick();
        drive(1, 1, 3, 0, 6, 1, 0, 0);
        tick();
        asserts++;
        if (sel_a !== 2'b00 || sel_b !== 2'b10) begin
            fails++;
            $display("FAIL mem_fwd_sel: sel_a=%0d sel_b=%0d need 0 2", sel_a, sel_b);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        drive(1, 1, 2, 0, 12, 1, 0, 0);
        tick();
        drive(1, 1, 2, 0, 12, 1, 0, 0);
        tick();
        drive(1, 12, 12, 0, 13, 1, 0, 0);
        tick();
        asserts++;
        if (sel_a !== 2'b01 || sel_b !== 2'b01) begin
            fails++;
            $display("FAIL youngest_sel: sel_a=%0d sel_b=%0d need 1 1", sel_a, sel_b);
        end
    endtask

    task automatic test_load_use();
        longint c0;
        drain();
        c0 = exp_cnt;
        drive(1, 1, 0, 1, 7, 1, 1, 0);
        tick();
        drive(1, 7, 7, 0, 8, 1, 0, 0);
        asserts++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL load_use_stall: got %0b need 1", stall);
        end
        tick();
        asserts++;
        if (sel_a !== 2'b00 || sel_b !== 2'b00 || stall !== 1'b0) begin
            fails++;
            $display("FAIL load_use_bubble: sel_a=%0d sel_b=%0d stall=%0b need 0 0 0", sel_a, sel_b, stall);
        end
        tick();
        asserts++;
        if (sel_a !== 2'b10 || sel_b !== 2'b10) begin
            fails++;
            $display("FAIL load_use_sel: sel_a=%0d sel_b=%0d need 2 2", sel_a, sel_b);
        end
`ifdef BYPASS_STALL_CNT_EN
        asserts++;
        if (stall_count !== 32'(c0 + 1)) begin
            fails++;
            $display("FAIL load_use_count: got %0d need %0d", stall_count, c0 + 1);
        end
`endif
    endtask

    task automatic test_r0_imm();
        drain();
        drive(1, 1, 0, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 9, 1, 0, 0);
        tick();
        asserts++;
        if (sel_a !== 2'b00 || sel_b !== 2'b11) begin
            fails++;
            $display("FAIL r0_imm_sel: sel_a=%0d sel_b=%0d need 0 3", sel_a, sel_b);
        end
    endtask

    task automatic test_flush_hazard();
        longint c0;
        drain();
        c0 = exp_cnt;
        drive(1, 1, 0, 1, 2, 1, 1, 0);
        tick();
        drive(1, 2, 2, 0, 5, 1, 0, 1);
        asserts++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_stall: got %0b need 0", stall);
        end
        tick();
        asserts++;
        if (sel_a !== 2'b00 || sel_b !== 2'b00) begin
            fails++;
            $display("FAIL flush_sel: sel_a=%0d sel_b=%0d need 0 0", sel_a, sel_b);
        end
`ifdef BYPASS_STALL_CNT_EN
        asserts++;
        if (stall_count !== 32'(c0)) begin
            fails++;
            $display("FAIL flush_count: got %0d need %0d", stall_count, c0);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        drain();
        drive(1, 1, 0, 1, 7, 1, 1, 0);
        tick();
        drive(1, 1, 7, 0, 8, 1, 0, 0);
        asserts++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL mid_stall_pre: got %0b need 1", stall);
        end
        reset = 1'b0;
        #1;
        asserts++;
        if (stall !== 1'b0 || sel_a !== 2'b00 || sel_b !== 2'b00) begin
            fails++;
            $display("FAIL mid_stall_reset: stall=%0b sel_a=%0d sel_b=%0d need 0 0 0", stall, sel_a, sel_b);
        end
`ifdef BYPASS_STALL_CNT_EN
        asserts++;
        if (stall_count !== 32'd0) begin
            fails++;
            $display("FAIL mid_stall_count: got %0d need 0", stall_count);
        end
`endif
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_random();
        bit s;
        for (int i = 0; i < 400; i++) begin
            if (!m_stall())
                drive($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
                      $urandom_range(3, 0) == 0, $urandom_range(7, 0), $urandom_range(4, 0) != 0,
                      $urandom_range(2, 0) == 0, $urandom_range(7, 0) == 0);
            s = m_stall();
            asserts++;
            if (stall !== s) begin
                fails++;
                $display("FAIL rand_stall[%0d]: got %0b need %0b", i, stall, s);
            end
            tick();
            asserts++;
            if (sel_a !== 2'(exp_a) || sel_b !== 2'(exp_b)) begin
                fails++;
                $display("FAIL rand_sel[%0d]: sel_a=%0d sel_b=%0d need %0d %0d", i, sel_a, sel_b, exp_a, exp_b);
            end
`ifdef BYPASS_STALL_CNT_EN
            asserts++;
            if (stall_count !== 32'(exp_cnt)) begin
                fails++;
                $display("FAIL rand_count[%0d]: got %0d need %0d", i, stall_count, exp_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_back_to_back();
        test_load_use();
        test_r0_imm();
        test_flush_hazard();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
